// File: rtl/ex_pipe.sv
// ex_pipe: multi-lane fixed-point e^x for the softmax path.
// Three registered stages per lane:
//   S1  optional saturating bias subtract, n = round(x / ln2)
//   S2  r = x - n*ln2, e_r = 1 + r + r^2/2
//   S3  scale e_r by 2^n, clamp to [0, 2^(DATA_W-1)-1]
//
// Handshake: a beat moves across any boundary on valid && ready. Stage k
// loads when stage k+1 is empty or advancing this cycle, so a full pipe
// streams one beat per cycle with no bubbles. in_ready is combinational
// from the stage valids and out_ready. A stalled stage holds data and tag.
module ex_pipe #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int FRAC_W = 6,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0]       in_bias,
  input  logic                    in_sub_en,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic [LANES-1:0]        out_sat
);

  // Working widths: p holds x*INV_LN2, r is the reduced argument,
  // e_r carries the full r^2 term, s holds e_r shifted up by n.
  localparam int P_W  = 2*DATA_W + 2;
  localparam int N_W  = DATA_W;
  localparam int R_W  = DATA_W + 2;
  localparam int ER_W = 2*R_W;
  localparam int S_W  = ER_W + DATA_W;

  // Rounded fixed-point constants, computed in integer arithmetic.
  localparam longint SCALE     = longint'(1) << FRAC_W;
  localparam longint INV_LN2_L = (64'sd14426950 * SCALE + 64'sd5000000) / 64'sd10000000;
  localparam longint LN2_L     = (64'sd6931472 * SCALE + 64'sd5000000) / 64'sd10000000;

  localparam logic signed [P_W-1:0]    INV_LN2 = P_W'(INV_LN2_L);
  localparam logic signed [R_W-1:0]    LN2     = R_W'(LN2_L);
  localparam logic        [P_W-1:0]    P_HALF  = P_W'(1) << (2*FRAC_W - 1);
  localparam logic signed [ER_W-1:0]   ONE     = ER_W'(1) << FRAC_W;
  localparam logic signed [DATA_W-1:0] X_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] X_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [S_W-1:0]    S_MAX   = {{(S_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [N_W-1:0]    N_HI    = N_W'(DATA_W);
  localparam logic signed [N_W-1:0]    N_LO    = N_W'(-(DATA_W + 2));

  // Pipeline control
  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  assign adv3      = out_ready || !v3;
  assign adv2      = !v2 || adv3;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v3;

  // Per-lane combinational results feeding each stage register
  logic signed [DATA_W-1:0] x_c   [LANES];
  logic signed [N_W-1:0]    n_c   [LANES];
  logic signed [ER_W-1:0]   er_c  [LANES];
  logic        [DATA_W-1:0] res_c [LANES];
  logic                     sat_c [LANES];

  // Stage registers
  logic signed [DATA_W-1:0] x1  [LANES];
  logic signed [N_W-1:0]    n1  [LANES];
  logic signed [ER_W-1:0]   er2 [LANES];
  logic signed [N_W-1:0]    n2  [LANES];
  logic [TAG_W-1:0]         tag1, tag2;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DATA_W-1:0] lane_x;
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W-1:0] x_sel;
    logic signed [P_W-1:0]    p;
    logic        [P_W-1:0]    p_mag;
    logic        [N_W-1:0]    q;
    logic signed [R_W-1:0]    r;
    logic signed [ER_W-1:0]   rr;
    logic signed [S_W-1:0]    er_ext;
    logic signed [S_W-1:0]    s;
    logic        [N_W-1:0]    sh;

    // S1: saturating bias subtract, then n = round-half-away(x * INV_LN2 / 2^2F)
    always_comb begin
      lane_x = in_data[l*DATA_W +: DATA_W];
      diff   = {lane_x[DATA_W-1], lane_x} - {in_bias[DATA_W-1], in_bias};
      x_sel  = lane_x;
      if (in_sub_en) begin
        if (diff[DATA_W] != diff[DATA_W-1]) begin
          x_sel = diff[DATA_W] ? X_MIN : X_MAX;
        end else begin
          x_sel = diff[DATA_W-1:0];
        end
      end
      p      = P_W'(x_sel) * INV_LN2;
      p_mag  = p[P_W-1] ? -p : p;
      q      = N_W'((p_mag + P_HALF) >> (2*FRAC_W));
      x_c[l] = x_sel;
      n_c[l] = p[P_W-1] ? -$signed(q) : $signed(q);
    end

    // S2: reduced argument and second-order polynomial for e^r
    always_comb begin
      r       = R_W'(x1[l]) - R_W'(n1[l]) * LN2;
      rr      = ER_W'(r) * ER_W'(r);
      er_c[l] = ONE + ER_W'(r) + (rr >>> (FRAC_W + 1));
    end

    // S3: scale by 2^n and clamp into the unsigned output range
    always_comb begin
      er_ext = S_W'(er2[l]);
      sh     = n2[l][N_W-1] ? N_W'(-n2[l]) : N_W'(n2[l]);
      s      = n2[l][N_W-1] ? (er_ext >>> sh) : (er_ext <<< sh);
      res_c[l] = s[DATA_W-1:0];
      sat_c[l] = 1'b0;
      if (n2[l] >= N_HI) begin
        res_c[l] = X_MAX;
        sat_c[l] = 1'b1;
      end else if (n2[l] <= N_LO) begin
        res_c[l] = '0;
      end else if (s[S_W-1]) begin
        res_c[l] = '0;
      end else if (s > S_MAX) begin
        res_c[l] = X_MAX;
        sat_c[l] = 1'b1;
      end
    end
  end

  // Stage valids, data and tags; each stage loads only when it may advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      tag1     <= '0;
      tag2     <= '0;
      out_tag  <= '0;
      out_data <= '0;
      out_sat  <= '0;
      for (int i = 0; i < LANES; i++) begin
        x1[i]  <= '0;
        n1[i]  <= '0;
        er2[i] <= '0;
        n2[i]  <= '0;
      end
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
      if (adv3) v3 <= v2;

      if (adv1 && in_valid) begin
        tag1 <= in_tag;
        for (int i = 0; i < LANES; i++) begin
          x1[i] <= x_c[i];
          n1[i] <= n_c[i];
        end
      end

      if (adv2 && v1) begin
        tag2 <= tag1;
        for (int i = 0; i < LANES; i++) begin
          er2[i] <= er_c[i];
          n2[i]  <= n1[i];
        end
      end

      if (adv3 && v2) begin
        out_tag <= tag2;
        for (int i = 0; i < LANES; i++) begin
          out_data[i*DATA_W +: DATA_W] <= res_c[i];
          out_sat[i]                   <= sat_c[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_pipe.sv
// Bench for ex_pipe (LANES=4, DATA_W=8, FRAC_W=6, TAG_W=4).
module tb_ex_pipe;

  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int FRAC_W = 6;
  localparam int TAG_W  = 4;
  localparam int E_W    = TAG_W + LANES + LANES*DATA_W;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic [DATA_W-1:0]       in_bias;
  logic                    in_sub_en;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic [TAG_W-1:0]        out_tag;
  logic [LANES-1:0]        out_sat;

  int n_vec = 0;
  int n_err = 0;
  logic [E_W-1:0] exp_q[$];

  ex_pipe #(
    .LANES(LANES), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_bias(in_bias), .in_sub_en(in_sub_en), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_sat(out_sat)
  );

  // Reference: e^(x/64)*64 via n = round(x/ln2), r = x - n*ln2, 1 + r + r^2/2
  function automatic void ref_lane(input int x, output int val, output bit sat);
    int p, n, r, er, s;
    p = x * 92;
    if (p >= 0) n = (p + 2048) / 4096;
    else        n = -((-p + 2048) / 4096);
    r  = x - n * 44;
    er = 64 + r + (r * r) / 128;
    if (n >= 0) s = er * (1 << n);
    else        s = er >>> (-n);
    sat = 1'b0;
    if (n >= 8)             begin val = 127; sat = 1'b1; end
    else if (n <= -10)      val = 0;
    else if (s < 0)         val = 0;
    else if (s > 127)       begin val = 127; sat = 1'b1; end
    else                    val = s;
  endfunction

  function automatic logic [E_W-1:0] ref_beat(input logic [31:0] d, input logic [7:0] b,
                                               input bit sub, input logic [3:0] tag);
    logic [31:0] od;
    logic [3:0]  os;
    int x, v;
    bit s;
    for (int l = 0; l < LANES; l++) begin
      x = int'($signed(d[l*8 +: 8]));
      if (sub) begin
        x = x - int'($signed(b));
        if (x > 127)  x = 127;
        if (x < -128) x = -128;
      end
      ref_lane(x, v, s);
      od[l*8 +: 8] = v[7:0];
      os[l] = s;
    end
    return {tag, os, od};
  endfunction

  // Driver: present one beat, then wait (bounded) for it to emerge
  task automatic apply_and_wait(input logic [31:0] d, input logic [7:0] b, input bit sub,
                                input logic [3:0] tag, output logic [E_W-1:0] got,
                                output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_bias = b; in_sub_en = sub; in_tag = tag;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = {out_tag, out_sat, out_data};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_bias = '0; in_sub_en = 1'b0;
    in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data: got %h exp 0", out_data); end
    n_vec++; if (out_tag !== '0) begin n_err++; $display("FAIL reset_tag: got %h exp 0", out_tag); end
    n_vec++; if (out_sat !== '0) begin n_err++; $display("FAIL reset_sat: got %b exp 0", out_sat); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_lanes();
    logic [E_W-1:0] got, e;
    logic [31:0] d;
    int lat;
    for (int k = 0; k < 7; k++) begin
      d = (k == 0) ? {8'h80, 8'hC0, 8'h20, 8'h00} : $urandom;
      e = ref_beat(d, 8'h00, 1'b0, k[3:0]);
      apply_and_wait(d, 8'h00, 1'b0, k[3:0], got, lat);
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL lanes_latency: got %0d exp 3", lat); end
      n_vec++; if (got !== e) begin n_err++; $display("FAIL lanes_value: got %h exp %h", got, e); end
    end
  endtask

  task automatic test_sat();
    logic [E_W-1:0] got, e;
    logic [31:0] d;
    int lat;
    for (int k = 0; k < 5; k++) begin
      d = (k == 0) ? {8'd43, 8'd44, 8'd127, 8'd64}
                   : {1'b0, 7'($urandom_range(30, 127)), 1'b0, 7'($urandom_range(30, 127)),
                      1'b0, 7'($urandom_range(30, 127)), 1'b0, 7'($urandom_range(30, 127))};
      e = ref_beat(d, 8'h00, 1'b0, 4'hA);
      apply_and_wait(d, 8'h00, 1'b0, 4'hA, got, lat);
      n_vec++; if (got !== e) begin n_err++; $display("FAIL sat_value: got %h exp %h", got, e); end
    end
  endtask

  task automatic test_bias();
    logic [E_W-1:0] got, e;
    logic [31:0] d;
    logic [7:0]  b;
    bit sub;
    int lat;
    for (int k = 0; k < 9; k++) begin
      d   = (k == 0) ? {8'd127, 8'h80, 8'd0, 8'd64} : $urandom;
      b   = (k == 0) ? 8'd64 : 8'($urandom);
      sub = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      e = ref_beat(d, b, sub, k[3:0]);
      apply_and_wait(d, b, sub, k[3:0], got, lat);
      n_vec++; if (got !== e) begin n_err++; $display("FAIL bias_value: got %h exp %h", got, e); end
    end
  endtask

  // Streaming with backpressure; occupancy decides when the pipe must stall
  task automatic test_back_to_back(input int nbeats, input bit rnd);
    int sent, recv, occ, cyc;
    bit pending, fire_in, fire_out;
    logic exp_ready;
    logic [E_W-1:0] e;
    logic [31:0] cd;
    logic [7:0]  cb;
    bit cs;
    sent = 0; recv = 0; occ = 0; cyc = 0; pending = 1'b0;
    exp_q.delete();
    cd = $urandom; cb = 8'($urandom); cs = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    while (recv < nbeats && cyc < 600) begin
      @(negedge clk);
      if (!pending && sent < nbeats) pending = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid = pending; in_data = cd; in_bias = cb; in_sub_en = cs; in_tag = sent[3:0];
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 3 && cyc <= 6);
      #1;
      exp_ready = !(occ == 3 && !out_ready);
      n_vec++;
      if (in_ready !== exp_ready) begin
        n_err++; $display("FAIL b2b_ready: cyc %0d got %b exp %b", cyc, in_ready, exp_ready);
      end
      if (occ == 0) begin
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty_valid: got %b exp 0", out_valid); end
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra: got %h exp none", {out_tag, out_sat, out_data});
        end else begin
          e = exp_q.pop_front();
          if ({out_tag, out_sat, out_data} !== e) begin
            n_err++; $display("FAIL b2b_value: got %h exp %h", {out_tag, out_sat, out_data}, e);
          end
        end
        recv++;
      end
      if (fire_in) begin
        exp_q.push_back(ref_beat(cd, cb, cs, sent[3:0]));
        sent++;
        pending = 1'b0;
        cd = $urandom; cb = 8'($urandom); cs = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      occ = occ + int'(fire_in) - int'(fire_out);
      cyc++;
    end
    if (recv < nbeats) begin
      n_vec++; n_err++;
      $display("FAIL b2b_timeout: got %0d beats exp %0d", recv, nbeats);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_flight();
    logic [E_W-1:0] got, e;
    logic [31:0] d;
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = $urandom; in_bias = '0; in_sub_en = 1'b0; in_tag = 4'(k + 5);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flight_pre_valid: got %b exp 1", out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flight_rst_valid: got %b exp 0", out_valid); end
    n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL flight_rst_data: got %h exp 0", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    d = $urandom;
    e = ref_beat(d, 8'h00, 1'b0, 4'h3);
    apply_and_wait(d, 8'h00, 1'b0, 4'h3, got, lat);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL flight_latency: got %0d exp 3", lat); end
    n_vec++; if (got !== e) begin n_err++; $display("FAIL flight_value: got %h exp %h", got, e); end
  endtask

  // Full input sweep, increasing x across lanes and beats
  task automatic test_sweep();
    logic [E_W-1:0] got, e;
    logic [31:0] d;
    int lat, x, v, prev;
    bit s;
    real ex, diff;
    prev = 0;
    for (int i = 0; i < 64; i++) begin
      for (int l = 0; l < LANES; l++) begin
        x = -128 + 4*i + l;
        d[l*8 +: 8] = x[7:0];
      end
      e = ref_beat(d, 8'h00, 1'b0, i[3:0]);
      apply_and_wait(d, 8'h00, 1'b0, i[3:0], got, lat);
      n_vec++; if (got !== e) begin n_err++; $display("FAIL sweep_value: got %h exp %h", got, e); end
      for (int l = 0; l < LANES; l++) begin
        x = -128 + 4*i + l;
        v = int'(got[l*8 +: 8]);
        s = got[LANES*DATA_W + l];
        if (!s) begin
          ex = $exp(real'(x) / 64.0) * 64.0;
          diff = real'(v) - ex;
          n_vec++;
          if (diff > 2.0 || diff < -2.0) begin
            n_err++; $display("FAIL sweep_accuracy: x %0d got %0d exp %f", x, v, ex);
          end
        end
        if (x > -128) begin
          n_vec++;
          if (v < prev) begin
            n_err++; $display("FAIL sweep_monotonic: x %0d got %0d exp >= %0d", x, v, prev);
          end
        end
        prev = v;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_sat();
    test_bias();
    test_back_to_back(10, 1'b0);
    test_back_to_back(60, 1'b1);
    test_reset_flight();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

endmodule
